// File: rtl/arb_grant_xfer.sv
// Grant-to-transfer stage: captures the granted port's payload on a one-hot arbiter grant and
// offers it on a single valid/ready master port, then pulses a one-cycle ack back to that port.
// Latency: grant -> m_valid_o 1 cycle; handshake -> ack_o 1 cycle; min capture spacing 4 cycles.
// Backpressure: payload is held while m_ready_i=0; req_mask_o closes the arbiter until IDLE.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge) and asynchronous active-low reset
//   gnt_i              registered one-hot grant from the arbiter
//   data_i             per-port payloads, port k at [k*DATA_W +: DATA_W]
//   req_mask_o         request gate back to the arbiter (all 1s only in IDLE)
//   m_valid_o/m_ready_i/m_data_o/m_id_o   master payload interface
//   ack_o              one-hot completion pulse to the winning port
//   busy_o             transfer outstanding (SEND or ACK)
//   err_o              sticky: a multi-hot grant was observed in IDLE
//   xfer_cnt_o         completed-transfer count, wraps modulo 2^CNT_W

module arb_grant_xfer #(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = $clog2(NUM_PORTS),
    parameter int CNT_W     = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_PORTS-1:0]        gnt_i,
    input  logic [NUM_PORTS*DATA_W-1:0] data_i,
    output logic [NUM_PORTS-1:0]        req_mask_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [DATA_W-1:0]           m_data_o,
    output logic [IDX_W-1:0]            m_id_o,
    output logic [NUM_PORTS-1:0]        ack_o,
    output logic                        busy_o,
    output logic                        err_o,
    output logic [CNT_W-1:0]            xfer_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                 r_valid;
    logic [DATA_W-1:0]    r_data;
    logic [IDX_W-1:0]     r_id;
    logic [NUM_PORTS-1:0] r_ack;
    logic                 r_busy;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_valid_nxt;
    logic [DATA_W-1:0]    w_data_nxt;
    logic [IDX_W-1:0]     w_id_nxt;
    logic [NUM_PORTS-1:0] w_ack_nxt;
    logic                 w_busy_nxt;
    logic                 w_err_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    // Grant decode: population count, encoded index and selected payload.
    // Index and payload are only meaningful when the grant is exactly one-hot.
    logic [IDX_W:0]       w_gnt_pop;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [DATA_W-1:0]    w_gnt_dat;
    logic                 w_gnt_onehot;
    logic                 w_gnt_multi;

    always_comb begin
        w_gnt_pop = '0;
        w_gnt_idx = '0;
        w_gnt_dat = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt_i[k]) begin
                w_gnt_pop = w_gnt_pop + (IDX_W+1)'(1);
                w_gnt_idx = IDX_W'(k);
                w_gnt_dat = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_gnt_onehot = (w_gnt_pop == (IDX_W+1)'(1));
    assign w_gnt_multi  = (w_gnt_pop >  (IDX_W+1)'(1));

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_id_nxt    = r_id;
        w_ack_nxt   = '0;
        w_busy_nxt  = r_busy;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_onehot) begin
                    w_data_nxt  = w_gnt_dat;
                    w_id_nxt    = w_gnt_idx;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SEND;
                end else if (w_gnt_multi) begin
                    w_err_nxt = 1'b1;
                end
            end
            ST_SEND: begin
                // gnt_i is deliberately not looked at here: the first SEND cycle
                // can carry a stale grant issued while the mask was still open.
                if (r_valid && m_ready_i) begin
                    w_valid_nxt = 1'b0;
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        w_ack_nxt[k] = (IDX_W'(k) == r_id);
                    end
                    // Count lands together with the ack so both are visible in ACK.
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_id    <= w_id_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Mask stays closed through ACK so the arbiter's registered grant is 0
    // in the first IDLE cycle after a transfer.
    assign req_mask_o = (r_state == ST_IDLE) ? {NUM_PORTS{1'b1}} : {NUM_PORTS{1'b0}};

    assign m_valid_o  = r_valid;
    assign m_data_o   = r_data;
    assign m_id_o     = r_id;
    assign ack_o      = r_ack;
    assign busy_o     = r_busy;
    assign err_o      = r_err;
    assign xfer_cnt_o = r_cnt;

endmodule

// File: tb/tb_arb_grant_xfer.sv
// Bench for arb_grant_xfer: directed scenarios plus randomized transfers checked against a
// transaction-level expectation (port, payload, wait count, running count, sticky error).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_arb_grant_xfer;

    localparam int NP    = 5;
    localparam int DW    = 32;
    localparam int IW    = $clog2(NP);
    localparam int CW    = 4;

    logic              clk_i;
    logic              rst_ni;
    logic [NP-1:0]     gnt_i;
    logic [NP*DW-1:0]  data_i;
    logic [NP-1:0]     req_mask_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [DW-1:0]     m_data_o;
    logic [IW-1:0]     m_id_o;
    logic [NP-1:0]     ack_o;
    logic              busy_o;
    logic              err_o;
    logic [CW-1:0]     xfer_cnt_o;

    int vec_cnt  = 0;
    int fail_cnt = 0;

    // Reference state: completed transfers since reset and sticky error.
    int exp_cnt  = 0;
    bit exp_err  = 1'b0;

    arb_grant_xfer #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .CNT_W     (CW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .gnt_i      (gnt_i),
        .data_i     (data_i),
        .req_mask_o (req_mask_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_data_o   (m_data_o),
        .m_id_o     (m_id_o),
        .ack_o      (ack_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .xfer_cnt_o (xfer_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic rand_data();
        for (int k = 0; k < NP; k++) data_i[k*DW +: DW] = $urandom;
    endtask

    // One complete transfer from IDLE: grant, 'waits' cycles of backpressure,
    // handshake, ACK, back in IDLE. Optionally a stale grant in the first SEND cycle.
    task automatic drive_xfer(input int port, input logic [DW-1:0] dat, input int waits,
                              input logic [NP-1:0] stale);
        logic [NP-1:0] exp_ack;
        exp_ack = '0;
        exp_ack[port] = 1'b1;
        rand_data();
        data_i[port*DW +: DW] = dat;
        gnt_i     = exp_ack;
        m_ready_i = 1'($urandom_range(0, 1));
        step();
        for (int w = 0; w <= waits; w++) begin
            vec_cnt++;
            if ({m_valid_o, busy_o} !== 2'b11) begin
                fail_cnt++;
                $display("FAIL send_valid_busy p%0d w%0d: got %b want 11", port, w, {m_valid_o, busy_o});
            end
            vec_cnt++;
            if (m_data_o !== dat || m_id_o !== IW'(port)) begin
                fail_cnt++;
                $display("FAIL send_payload p%0d w%0d: got %h/%0d want %h/%0d", port, w, m_data_o, m_id_o, dat, port);
            end
            vec_cnt++;
            if (ack_o !== '0 || req_mask_o !== '0) begin
                fail_cnt++;
                $display("FAIL send_ack_mask p%0d w%0d: got ack %b mask %b want 0/0", port, w, ack_o, req_mask_o);
            end
            vec_cnt++;
            if (err_o !== exp_err) begin
                fail_cnt++;
                $display("FAIL send_err p%0d w%0d: got %b want %b", port, w, err_o, exp_err);
            end
            gnt_i     = (w == 0) ? stale : '0;
            m_ready_i = (w == waits);
            rand_data();
            step();
        end
        exp_cnt++;
        gnt_i     = '0;
        m_ready_i = 1'($urandom_range(0, 1));
        vec_cnt++;
        if (ack_o !== exp_ack) begin
            fail_cnt++;
            $display("FAIL ack_pulse p%0d: got %b want %b", port, ack_o, exp_ack);
        end
        vec_cnt++;
        if ({m_valid_o, busy_o, req_mask_o} !== {2'b01, {NP{1'b0}}}) begin
            fail_cnt++;
            $display("FAIL ack_state p%0d: got v%b b%b m%b want v0 b1 m0", port, m_valid_o, busy_o, req_mask_o);
        end
        vec_cnt++;
        if (xfer_cnt_o !== CW'(exp_cnt)) begin
            fail_cnt++;
            $display("FAIL ack_count p%0d: got %0d want %0d", port, xfer_cnt_o, CW'(exp_cnt));
        end
        step();
        vec_cnt++;
        if ({ack_o, m_valid_o, busy_o, req_mask_o} !== {{NP{1'b0}}, 2'b00, {NP{1'b1}}}) begin
            fail_cnt++;
            $display("FAIL idle_return p%0d: got ack %b v%b b%b m%b want 0 0 0 11111", port, ack_o, m_valid_o, busy_o, req_mask_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        gnt_i = '0;
        m_ready_i = 1'b0;
        rand_data();
        step();
        step();
        rst_ni = 1'b1;
        exp_cnt = 0;
        exp_err = 1'b0;
        step();
        vec_cnt++;
        if ({m_valid_o, busy_o, err_o, ack_o, req_mask_o} !== {3'b000, {NP{1'b0}}, {NP{1'b1}}}) begin
            fail_cnt++;
            $display("FAIL reset_ctrl: got v%b b%b e%b ack %b m%b want 000 0 11111", m_valid_o, busy_o, err_o, ack_o, req_mask_o);
        end
        vec_cnt++;
        if (m_data_o !== '0 || m_id_o !== '0 || xfer_cnt_o !== '0) begin
            fail_cnt++;
            $display("FAIL reset_data: got %h/%0d/%0d want 0/0/0", m_data_o, m_id_o, xfer_cnt_o);
        end
    endtask

    task automatic test_basic();
        drive_xfer(2, 32'hCAFE0002, 0, '0);
    endtask

    task automatic test_backpressure();
        drive_xfer(0, $urandom, 6, '0);
    endtask

    task automatic test_stale_grant();
        drive_xfer(1, $urandom, $urandom_range(0, 3), 5'b01000);
    endtask

    task automatic test_multi_hot();
        gnt_i = 5'b00011;
        step();
        gnt_i = '0;
        exp_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if ({err_o, m_valid_o, busy_o, req_mask_o} !== {3'b100, {NP{1'b1}}}) begin
                fail_cnt++;
                $display("FAIL multi_hot c%0d: got e%b v%b b%b m%b want e1 v0 b0 m11111", i, err_o, m_valid_o, busy_o, req_mask_o);
            end
            step();
        end
        drive_xfer(1, $urandom, 1, '0);
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i < 17; i++) begin
            drive_xfer($urandom_range(0, NP-1), $urandom, $urandom_range(0, 2), '0);
        end
        vec_cnt++;
        if (xfer_cnt_o !== CW'(1)) begin
            fail_cnt++;
            $display("FAIL count_wrap: got %0d want 1", xfer_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        gnt_i = 5'b10000;
        m_ready_i = 1'b0;
        step();
        gnt_i = '0;
        step();
        #1 rst_ni = 1'b0;
        #1;
        vec_cnt++;
        if ({m_valid_o, req_mask_o, xfer_cnt_o, ack_o} !== {1'b0, {NP{1'b1}}, {CW{1'b0}}, {NP{1'b0}}}) begin
            fail_cnt++;
            $display("FAIL reset_mid: got v%b m%b cnt %0d ack %b want v0 m11111 cnt 0 ack 0", m_valid_o, req_mask_o, xfer_cnt_o, ack_o);
        end
        m_ready_i = 1'b1;
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vec_cnt++;
            if (ack_o !== '0 || xfer_cnt_o !== '0 || m_valid_o !== 1'b0) begin
                fail_cnt++;
                $display("FAIL reset_mid_after c%0d: got ack %b cnt %0d v%b want 0 0 0", i, ack_o, xfer_cnt_o, m_valid_o);
            end
        end
        m_ready_i = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [NP-1:0] stale;
            stale = NP'($urandom_range(0, (1 << NP) - 1));
            if ($urandom_range(0, 1) == 0) stale = '0;
            drive_xfer($urandom_range(0, NP-1), $urandom, $urandom_range(0, 4), stale);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stale_grant();
        test_multi_hot();
        test_random();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
